// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classifiers for alu_ctrl.
// Division support is selected by ALU_CTRL_DIV_EN in alu_ctrl.
package alu_pkg;

  localparam logic [3:0] OP_IADD = 4'b0000;
  localparam logic [3:0] OP_ISUB = 4'b0001;
  localparam logic [3:0] OP_IMUL = 4'b0010;
  localparam logic [3:0] OP_IDIV = 4'b0011;
  localparam logic [3:0] OP_IREM = 4'b0100;
  localparam logic [3:0] OP_INEG = 4'b0101;
  localparam logic [3:0] OP_PARK = 4'b0111;
  localparam logic [3:0] OP_IOR  = 4'b1000;
  localparam logic [3:0] OP_IXOR = 4'b1001;
  localparam logic [3:0] OP_IINC = 4'b1010;
  localparam logic [3:0] OP_ISHL = 4'b1100;
  localparam logic [3:0] OP_ISHR = 4'b1101;
  localparam logic [3:0] OP_IAND = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_t;

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return (op == OP_IADD) || (op == OP_ISUB) ||
           (op == OP_INEG) || (op == OP_IOR)  ||
           (op == OP_IXOR) || (op == OP_IINC) ||
           (op == OP_ISHL) || (op == OP_ISHR) ||
           (op == OP_IAND);
  endfunction

  function automatic logic is_div_op(
    input logic [3:0] op
  );
    return (op == OP_IDIV) || (op == OP_IREM);
  endfunction

  function automatic logic [31:0] mag32(
    input logic [31:0] x
  );
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Only instantiated by alu_ctrl when ALU_CTRL_DIV_EN is defined.
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Load on start, then one shift-subtract step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= CW'(DIV_STEPS);
      end else if (cnt != '0) begin
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign busy      = (cnt != '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer between execute stage and combinational ALU.
// ALU_CTRL_DIV_EN builds the iterative IDIV/IREM path.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  state_t           state;
  state_t           state_n;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_n;
  logic             err_n;
  logic             accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = (state == EXEC) ? op_q : OP_PARK;

`ifdef ALU_CTRL_DIV_EN
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] div_res;

  alu_div_iter #(
    .WIDTH     (WIDTH),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag32(in_a)),
    .divisor   (mag32(in_b)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Sign fixup: quotient negative on sign mismatch, remainder follows dividend
  always_comb begin
    q_fix   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~div_q + 1'b1) : div_q;
    r_fix   = a_q[WIDTH-1] ? (~div_r + 1'b1) : div_r;
    div_res = (op_q == OP_IREM) ? r_fix : q_fix;
  end
`endif

  // Next-state and result selection
  always_comb begin
    state_n = state;
    res_n   = out_result;
    err_n   = out_err;
`ifdef ALU_CTRL_DIV_EN
    div_start = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_alu_op(in_op)) begin
            state_n = EXEC;
`ifdef ALU_CTRL_DIV_EN
          end else if (is_div_op(in_op) && (in_b != '0)) begin
            state_n   = DIV;
            div_start = 1'b1;
`endif
          end else begin
            state_n = DONE;
            res_n   = '0;
            err_n   = 1'b1;
          end
        end
      end
      EXEC: begin
        state_n = DONE;
        res_n   = alu_lo;
        err_n   = 1'b0;
      end
`ifdef ALU_CTRL_DIV_EN
      DIV: begin
        if (div_done && !div_busy) begin
          state_n = DONE;
          res_n   = div_res;
          err_n   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, operand latches and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      state      <= state_n;
      out_result <= res_n;
      out_err    <= err_n;
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural ALU stand-in.
// Division expectations follow ALU_CTRL_DIV_EN.
module tb_alu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int n_chk;
  int n_fail;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  alu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_lo     (alu_lo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU
  always_comb begin
    alu_lo = 32'hDEADBEEF;
    case (alu_op)
      4'b0000: alu_lo = alu_a + alu_b;
      4'b0001: alu_lo = alu_a - alu_b;
      4'b0101: alu_lo = -alu_a;
      4'b1000: alu_lo = alu_a | alu_b;
      4'b1001: alu_lo = alu_a ^ alu_b;
      4'b1010: alu_lo = alu_a + 32'd1;
      4'b1100: alu_lo = alu_a << alu_b[4:0];
      4'b1101: alu_lo = alu_a >> alu_b[4:0];
      4'b1111: alu_lo = alu_a & alu_b;
      default: alu_lo = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic err,
                     input int lat, input int hold);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b;
    v.res = res; v.err = err; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    in_op = v.op; in_a = v.a; in_b = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1)
        chk({v.name, " alu_op c1"}, {28'd0, alu_op},
            {28'd0, (v.lat == 2) ? v.op : 4'b0111});
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: got no out_valid expected cycle %0d",
               v.name, v.lat);
      do_reset();
      return;
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " result"}, out_result, v.res);
    chk({v.name, " err"}, {31'd0, out_err}, {31'd0, v.err});
    chk({v.name, " alu_op done"}, {28'd0, alu_op}, 32'h7);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({v.name, " held valid"}, {31'd0, out_valid}, 32'd1);
      chk({v.name, " held result"}, out_result, v.res);
      chk({v.name, " held err"}, {31'd0, out_err}, {31'd0, v.err});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 4'd0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;

    add("iadd ovf", 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 2, 0);
    add("isub",     4'b0001, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 2, 0);
    add("ineg",     4'b0101, 32'd1, 32'd9, 32'hFFFFFFFF, 1'b0, 2, 0);
    add("ior",      4'b1000, 32'hF0, 32'h0F, 32'hFF, 1'b0, 2, 0);
    add("ixor",     4'b1001, 32'hFF, 32'h0F, 32'hF0, 1'b0, 2, 2);
    add("iand",     4'b1111, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 2, 0);
    add("ishl",     4'b1100, 32'd1, 32'd4, 32'h10, 1'b0, 2, 0);
    add("ishr",     4'b1101, 32'h80000000, 32'd1, 32'h40000000, 1'b0, 2, 0);
    add("iinc",     4'b1010, 32'd5, 32'd7, 32'd6, 1'b0, 2, 0);
    add("imul",     4'b0010, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
    add("op1110",   4'b1110, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
    add("op0110",   4'b0110, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
    add("op1011",   4'b1011, 32'd3, 32'd4, 32'd0, 1'b1, 1, 1);
    add("irem by0", 4'b0100, 32'd9, 32'd0, 32'd0, 1'b1, 1, 0);
    add("idiv by0", 4'b0011, 32'd5, 32'd0, 32'd0, 1'b1, 1, 0);
`ifdef ALU_CTRL_DIV_EN
    add("idiv -7/2", 4'b0011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34, 5);
    add("irem -7/2", 4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34, 5);
    add("idiv min/-1", 4'b0011, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 1'b0, 34, 0);
    add("irem min/-1", 4'b0100, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 1'b0, 34, 0);
    add("idiv 100/7", 4'b0011, 32'd100, 32'd7, 32'd14, 1'b0, 34, 0);
    add("irem 100/-7", 4'b0100, 32'd100, 32'hFFFFFFF9, 32'd2, 1'b0, 34, 0);
    add("idiv -100/-7", 4'b0011, 32'hFFFFFF9C, 32'hFFFFFFF9,
        32'd14, 1'b0, 34, 0);
    add("idiv max/1", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 34, 0);
`else
    add("idiv 8/2 off", 4'b0011, 32'd8, 32'd2, 32'd0, 1'b1, 1, 0);
    add("irem -7/2 off", 4'b0100, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b1, 1, 3);
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst alu_op", {28'd0, alu_op}, 32'h7);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_err", {31'd0, out_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of an op aborts it
    in_valid = 1'b1;
`ifdef ALU_CTRL_DIV_EN
    in_op = 4'b0011; in_a = 32'd100; in_b = 32'd7;
`else
    in_op = 4'b0000; in_a = 32'd1; in_b = 32'd2;
`endif
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_CTRL_DIV_EN
    repeat (4) @(negedge clk);
`endif
    chk("busy in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1 chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst alu_op", {28'd0, alu_op}, 32'h7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("aborted no output", {31'd0, seen}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back ISHR then IINC with out_ready held high
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 4'b1101; in_a = 32'h80000000; in_b = 32'd1;
    @(posedge clk);
    #1 in_op = 4'b1010; in_a = 32'd5; in_b = 32'd3;
    @(negedge clk);
    chk("b2b c1 alu_op", {28'd0, alu_op}, 32'hD);
    chk("b2b c1 in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("b2b c2 alu_op", {28'd0, alu_op}, 32'h7);
    chk("b2b c2 valid", {31'd0, out_valid}, 32'd1);
    chk("b2b c2 result", out_result, 32'h40000000);
    chk("b2b c2 in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("b2b c3 alu_op", {28'd0, alu_op}, 32'h7);
    chk("b2b c3 valid", {31'd0, out_valid}, 32'd0);
    chk("b2b c3 in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b c4 alu_op", {28'd0, alu_op}, 32'hA);
    chk("b2b c4 alu_a", alu_a, 32'd5);
    @(negedge clk);
    chk("b2b c5 valid", {31'd0, out_valid}, 32'd1);
    chk("b2b c5 result", out_result, 32'd6);
    chk("b2b c5 err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
